// File: rtl/bmult12x12_booth_ppgen.sv
// Radix-4 Booth partial-product generator for a 12x12 signed multiply.
// Registers operands, recodes b into six digits and emits a 24-column bit heap.
module bmult12x12_booth_ppgen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  output logic             out_valid,
  output logic [1:0]       out_col0,
  output logic [0:0]       out_col1,
  output logic [2:0]       out_col2,
  output logic [1:0]       out_col3,
  output logic [3:0]       out_col4,
  output logic [2:0]       out_col5,
  output logic [4:0]       out_col6,
  output logic [3:0]       out_col7,
  output logic [5:0]       out_col8,
  output logic [4:0]       out_col9,
  output logic [6:0]       out_col10,
  output logic [5:0]       out_col11,
  output logic [6:0]       out_col12,
  output logic [5:0]       out_col13,
  output logic [4:0]       out_col14,
  output logic [4:0]       out_col15,
  output logic [3:0]       out_col16,
  output logic [3:0]       out_col17,
  output logic [2:0]       out_col18,
  output logic [2:0]       out_col19,
  output logic [1:0]       out_col20,
  output logic [1:0]       out_col21,
  output logic [0:0]       out_col22,
  output logic [0:0]       out_col23,
  output logic [CNT_W-1:0] out_cnt
);

  // Column geometry: rows i with 0 <= c-2i <= 12, then the neg bit, then the constant one.
  function automatic int row_lo(input int c);
    return (c <= 12) ? 0 : (c - 11) / 2;
  endfunction

  function automatic int row_hi(input int c);
    return (c / 2 < 5) ? c / 2 : 5;
  endfunction

  function automatic int n_rows(input int c);
    return (row_hi(c) >= row_lo(c)) ? row_hi(c) - row_lo(c) + 1 : 0;
  endfunction

  function automatic int has_neg(input int c);
    return ((c % 2 == 0) && (c <= 10)) ? 1 : 0;
  endfunction

  // Constant 2^12 * 2731 cancels the six inverted sign bits modulo 2^24.
  function automatic int has_one(input int c);
    return ((c == 12) || ((c >= 13) && (c % 2 == 1))) ? 1 : 0;
  endfunction

  function automatic int col_w(input int c);
    return n_rows(c) + has_neg(c) + has_one(c);
  endfunction

  function automatic int col_off(input int c);
    int s;
    s = 0;
    for (int k = 0; k < c; k++) s += col_w(k);
    return s;
  endfunction

  localparam int HEAP_W = col_off(24);

  logic              r_valid;
  logic [11:0]       r_a;
  logic [11:0]       r_b;
  logic              r_out_valid;
  logic [HEAP_W-1:0] r_heap;
  logic [CNT_W-1:0]  r_cnt;

  logic [12:0]       w_b_ext;
  logic [12:0]       w_pp [6];
  logic [5:0]        w_neg;
  logic [HEAP_W-1:0] w_heap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_valid <= in_valid;
      r_a     <= in_a;
      r_b     <= in_b;
    end
  end

  assign w_b_ext = {r_b, 1'b0};

  genvar gi, gj;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_booth
      logic [2:0]  w_dig;
      logic [12:0] w_mult;

      assign w_dig = w_b_ext[2*gi +: 3];

      always_comb begin
        w_mult = '0;
        case (w_dig)
          3'b001, 3'b010, 3'b101, 3'b110: w_mult = {r_a[11], r_a};
          3'b011, 3'b100:                 w_mult = {r_a, 1'b0};
          default:                        w_mult = '0;
        endcase
      end

      // 3'b111 is digit 0, so it must not raise neg.
      assign w_neg[gi] = w_dig[2] & ~(w_dig[1] & w_dig[0]);
      assign w_pp[gi]  = (w_neg[gi] ? ~w_mult : w_mult) ^ 13'h1000;
    end

    for (gi = 0; gi < 24; gi++) begin : g_col
      localparam int OFF = col_off(gi);
      localparam int LO  = row_lo(gi);
      localparam int NR  = n_rows(gi);

      for (gj = 0; gj < 6; gj++) begin : g_row
        if ((gj >= LO) && (gj < LO + NR)) begin : g_bit
          assign w_heap[OFF + gj - LO] = w_pp[gj][gi - 2*gj];
        end
      end

      if (has_neg(gi) == 1) begin : g_neg
        assign w_heap[OFF + NR] = w_neg[gi/2];
      end

      if (has_one(gi) == 1) begin : g_one
        assign w_heap[OFF + NR + has_neg(gi)] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_heap      <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= r_valid;
      r_heap      <= r_valid ? w_heap : '0;
      if (r_valid) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_out_valid;
  assign out_cnt   = r_cnt;

  assign out_col0  = r_heap[col_off(0)  +: 2];
  assign out_col1  = r_heap[col_off(1)  +: 1];
  assign out_col2  = r_heap[col_off(2)  +: 3];
  assign out_col3  = r_heap[col_off(3)  +: 2];
  assign out_col4  = r_heap[col_off(4)  +: 4];
  assign out_col5  = r_heap[col_off(5)  +: 3];
  assign out_col6  = r_heap[col_off(6)  +: 5];
  assign out_col7  = r_heap[col_off(7)  +: 4];
  assign out_col8  = r_heap[col_off(8)  +: 6];
  assign out_col9  = r_heap[col_off(9)  +: 5];
  assign out_col10 = r_heap[col_off(10) +: 7];
  assign out_col11 = r_heap[col_off(11) +: 6];
  assign out_col12 = r_heap[col_off(12) +: 7];
  assign out_col13 = r_heap[col_off(13) +: 6];
  assign out_col14 = r_heap[col_off(14) +: 5];
  assign out_col15 = r_heap[col_off(15) +: 5];
  assign out_col16 = r_heap[col_off(16) +: 4];
  assign out_col17 = r_heap[col_off(17) +: 4];
  assign out_col18 = r_heap[col_off(18) +: 3];
  assign out_col19 = r_heap[col_off(19) +: 3];
  assign out_col20 = r_heap[col_off(20) +: 2];
  assign out_col21 = r_heap[col_off(21) +: 2];
  assign out_col22 = r_heap[col_off(22) +: 1];
  assign out_col23 = r_heap[col_off(23) +: 1];

endmodule

// File: tb/tb_bmult12x12_booth_ppgen.sv
// Scoreboard bench: expected products are queued at drive time and compared
// against the weighted popcount of the emitted heap two edges later.
module tb_bmult12x12_booth_ppgen;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [11:0]      in_a;
  logic [11:0]      in_b;
  logic             out_valid;
  logic [1:0]       out_col0;
  logic [0:0]       out_col1;
  logic [2:0]       out_col2;
  logic [1:0]       out_col3;
  logic [3:0]       out_col4;
  logic [2:0]       out_col5;
  logic [4:0]       out_col6;
  logic [3:0]       out_col7;
  logic [5:0]       out_col8;
  logic [4:0]       out_col9;
  logic [6:0]       out_col10;
  logic [5:0]       out_col11;
  logic [6:0]       out_col12;
  logic [5:0]       out_col13;
  logic [4:0]       out_col14;
  logic [4:0]       out_col15;
  logic [3:0]       out_col16;
  logic [3:0]       out_col17;
  logic [2:0]       out_col18;
  logic [2:0]       out_col19;
  logic [1:0]       out_col20;
  logic [1:0]       out_col21;
  logic [0:0]       out_col22;
  logic [0:0]       out_col23;
  logic [CNT_W-1:0] out_cnt;

  bmult12x12_booth_ppgen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid),
    .out_col0(out_col0), .out_col1(out_col1), .out_col2(out_col2), .out_col3(out_col3),
    .out_col4(out_col4), .out_col5(out_col5), .out_col6(out_col6), .out_col7(out_col7),
    .out_col8(out_col8), .out_col9(out_col9), .out_col10(out_col10), .out_col11(out_col11),
    .out_col12(out_col12), .out_col13(out_col13), .out_col14(out_col14), .out_col15(out_col15),
    .out_col16(out_col16), .out_col17(out_col17), .out_col18(out_col18), .out_col19(out_col19),
    .out_col20(out_col20), .out_col21(out_col21), .out_col22(out_col22), .out_col23(out_col23),
    .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] p;
  } item_t;

  item_t      sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_cnt  = '0;
  logic       saw_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] heap_sum();
    int pc[24];
    logic [31:0] s;
    pc[0]  = $countones(out_col0);  pc[1]  = $countones(out_col1);
    pc[2]  = $countones(out_col2);  pc[3]  = $countones(out_col3);
    pc[4]  = $countones(out_col4);  pc[5]  = $countones(out_col5);
    pc[6]  = $countones(out_col6);  pc[7]  = $countones(out_col7);
    pc[8]  = $countones(out_col8);  pc[9]  = $countones(out_col9);
    pc[10] = $countones(out_col10); pc[11] = $countones(out_col11);
    pc[12] = $countones(out_col12); pc[13] = $countones(out_col13);
    pc[14] = $countones(out_col14); pc[15] = $countones(out_col15);
    pc[16] = $countones(out_col16); pc[17] = $countones(out_col17);
    pc[18] = $countones(out_col18); pc[19] = $countones(out_col19);
    pc[20] = $countones(out_col20); pc[21] = $countones(out_col21);
    pc[22] = $countones(out_col22); pc[23] = $countones(out_col23);
    s = '0;
    for (int c = 0; c < 24; c++) s = s + (32'(pc[c]) << c);
    return s[23:0];
  endfunction

  function automatic int heap_ones();
    return $countones({out_col0, out_col1, out_col2, out_col3, out_col4, out_col5,
                       out_col6, out_col7, out_col8, out_col9, out_col10, out_col11,
                       out_col12, out_col13, out_col14, out_col15, out_col16, out_col17,
                       out_col18, out_col19, out_col20, out_col21, out_col22, out_col23});
  endfunction

  task automatic check_out(input item_t it);
    logic [3:0] prev;
    check("valid", 32'(out_valid), 32'(it.v));
    if (it.v) begin
      prev    = exp_cnt;
      exp_cnt = exp_cnt + 4'd1;
      if (prev == 4'd15 && out_cnt == 4'd0) saw_wrap = 1'b1;
      check("sum", 32'(heap_sum()), 32'(it.p));
    end else begin
      check("bubble_zero", 32'(heap_ones()), 32'd0);
    end
    check("cnt", 32'(out_cnt), 32'(exp_cnt));
    $display("txn v=%0b a=%0d b=%0d sum=%06h exp=%06h cnt=%0d",
             it.v, $signed(it.a), $signed(it.b), heap_sum(), it.p, out_cnt);
  endtask

  task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b);
    item_t it;
    int pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    it.v = v;
    it.a = a;
    it.b = b;
    it.p = p[23:0];
    in_valid = v;
    in_a     = a;
    in_b     = b;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    if (sb_q.size() == 2) check_out(sb_q.pop_front());
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cnt",   32'(out_cnt),   32'd0);
    check("rst_heap",  32'(heap_ones()), 32'd0);
    rst_n = 1'b1;

    // Single, zero operands, corners back-to-back, then a bubble pattern.
    step(1'b1, 12'd3,   12'd5);
    step(1'b1, 12'd0,   12'd0);
    step(1'b1, 12'h800, 12'h800);
    step(1'b1, 12'h7FF, 12'h800);
    step(1'b1, 12'hFFF, 12'hFFF);
    step(1'b1, 12'd100, 12'hFF9);
    step(1'b0, 12'hABC, 12'h555);
    step(1'b1, 12'hED4, 12'd25);
    step(1'b0, 12'h000, 12'h000);
    step(1'b0, 12'h000, 12'h000);

    // Reset while a valid operand sits in stage 1.
    step(1'b1, 12'd77, 12'd91);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_cnt",   32'(out_cnt),   32'd0);
    check("midrst_heap",  32'(heap_ones()), 32'd0);
    sb_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 12'd0, 12'd0);
    step(1'b0, 12'd0, 12'd0);
    step(1'b0, 12'd0, 12'd0);

    for (int n = 0; n < 20000; n++) begin
      step(($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom));
    end
    step(1'b0, 12'd0, 12'd0);
    step(1'b0, 12'd0, 12'd0);
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
